// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: runs a req/gnt/rvalid transaction at the current pc
// and hands the returned word to decode over a valid/ready handshake.
//
// state  | meaning
// IDLE   | capture pc into addr_q; start a request unless a redirect is updating pc
// REQ    | mem_req held at addr_q until granted; a redirect here marks the fetch for dropping
// WAIT   | granted, waiting for rvalid; a redirect turns the fetch into a drop
// DROP   | waiting for an orphaned response so it can be discarded
// HOLD   | instr_valid asserted until decode accepts or a redirect cancels it
module ifetch_ctrl #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_load,
  input  logic        redirect,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic [31:0] addr_q;
  logic        drop;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        fire;
  logic        tmo_hit;

  assign fire     = instr_valid & id_ready & ~redirect;
  assign pc_load  = fire | redirect;
  assign mem_req  = (state == S_REQ);
  assign mem_addr = addr_q;
  assign cnt_inc  = cnt + 16'd1;
  // A response arriving on the very edge the limit is reached is not late.
  assign tmo_hit  = (cnt_inc == TMO) & ~mem_rvalid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      drop        <= 1'b0;
      cnt         <= '0;
      instr       <= RESET_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_q <= pc;
          if (!redirect) state <= S_REQ;
        end
        S_REQ: begin
          if (redirect) drop <= 1'b1;
          if (mem_gnt) begin
            cnt   <= '0;
            state <= (drop || redirect) ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != TMO) cnt <= cnt_inc;
          if (tmo_hit) fetch_err <= 1'b1;
          if (mem_rvalid) begin
            if (!redirect) begin
              instr       <= mem_rdata;
              instr_pc    <= addr_q;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end else begin
              state <= S_IDLE;
            end
          end else if (redirect) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (cnt != TMO) cnt <= cnt_inc;
          if (tmo_hit) fetch_err <= 1'b1;
          if (mem_rvalid) begin
            drop  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (fire || redirect) begin
            instr_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer that sits between the program counter register and the instruction memory port. It reads the current word address `pc` and runs a request/grant/response transaction to memory. It presents the returned instruction to decode with a valid/ready handshake. It generates the `load` strobe that advances or redirects the PC, on hand-off to decode or on a branch/jump redirect.

Parameters:
RESET_INSTR, 32'h00000013, value driven on `instr` after reset (NOP).
TIMEOUT, 64, max cycles in WAIT before `fetch_err` sets; range 2..65535.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
pc  in  32  current word address from the PC register.
pc_load  out  1  load strobe to the PC register; asserted only in the cycle the PC must update.
redirect  in  1  execute resolved a taken jal/jalr/branch; `pc_sel` and the target are valid this cycle.
mem_req  out  1  memory read request.
mem_addr  out  32  memory word address; stable while `mem_req`=1.
mem_gnt  in  1  memory accepted the request this cycle.
mem_rvalid  in  1  read data valid; at most one per grant; earliest one cycle after grant.
mem_rdata  in  32  read data.
instr  out  32  instruction to decode.
instr_pc  out  32  word address `instr` was fetched from.
instr_valid  out  1  `instr` valid.
id_ready  in  1  decode accepts `instr` this cycle.
fetch_err  out  1  sticky: a response exceeded TIMEOUT.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; mem_req=0; instr_valid=0; pc_load=0; fetch_err=0.
  - instr=RESET_INSTR; instr_pc=0; addr_q=0; timeout counter=0; drop flag=0.
  - Reset wins over every other input in any state, including an in-flight transaction. An rvalid arriving after reset for a pre-reset grant is ignored, because the state is IDLE.
- Registers: state, addr_q, instr, instr_pc, instr_valid, drop, wait counter, fetch_err. `pc_load` and `mem_req` are combinational decodes of state and inputs.
- fire = instr_valid & id_ready & ~redirect.
- pc_load = fire | redirect. Redirect has priority: decode must not consume `instr` in a redirect cycle.
- States:
  - IDLE: addr_q<=pc. If redirect, stay IDLE so the updated pc is recaptured. Else go to REQ.
  - REQ: mem_req=1, mem_addr=addr_q.
    - A request is never withdrawn before grant.
    - redirect sets drop<=1 and stays in REQ.
    - On mem_gnt: go to DROP if drop (or redirect this cycle), else go to WAIT. Clear the counter.
  - WAIT: counter increments each cycle.
    - rvalid & ~redirect: instr<=mem_rdata, instr_pc<=addr_q, instr_valid<=1, go to HOLD.
    - rvalid & redirect: discard the data, go to IDLE.
    - redirect only: go to DROP.
    - When the counter reaches TIMEOUT, fetch_err<=1. Remain in WAIT; the counter saturates.
  - DROP: wait for the orphaned response. On rvalid, discard it, clear drop, go to IDLE. The counter and timeout apply as in WAIT.
  - HOLD: instr_valid=1; instr and instr_pc are held stable.
    - fire: instr_valid<=0, go to IDLE.
    - redirect: instr_valid<=0, go to IDLE.
    - Otherwise stay in HOLD (backpressure).
- Timing:
  - Minimum latency from IDLE to instr_valid with gnt in the first REQ cycle and rvalid one cycle later: 3 cycles (IDLE, REQ, WAIT, then HOLD).
  - Steady-state throughput is 1 instruction per 4 cycles minimum.
- The PC register changes only on the edge where pc_load=1. This block never assumes pc+1 arithmetic; it always re-reads pc in IDLE.
- rvalid or gnt in a state that does not expect it (IDLE, HOLD, or gnt outside REQ) is ignored. This does not cause an error.
- fetch_err clears only on reset.

Test Plan:
1. Basic fetch: release reset with pc=0. gnt in the first REQ cycle, rvalid+rdata=32'h00500093 one cycle later, id_ready=1.
   -> instr_valid rises at cycle 3; instr=32'h00500093, instr_pc=0; pc_load pulses once that cycle; the next mem_addr=1.
2. Backpressure: hold id_ready=0 for 5 cycles in HOLD.
   -> instr and instr_pc stable; pc_load=0 throughout; a single pc_load fires when id_ready rises.
3. Redirect in WAIT: pc=8 granted, redirect pulse with target 20, rvalid=32'hDEADBEEF 2 cycles later.
   -> pc_load=1 on the redirect cycle; DEADBEEF never appears with instr_valid=1; the next mem_addr=20.
4. Redirect in REQ with gnt delayed 3 cycles.
   -> mem_req held continuously with mem_addr=old pc; the subsequent response is dropped; the next request uses the new pc.
5. Timeout: gnt, then no rvalid for TIMEOUT=64 cycles.
   -> fetch_err=1 at cycle 64 after gnt and stays 1; a late rvalid still completes the fetch; reset clears fetch_err.
6. Reset mid-fetch: reset=0 in WAIT, rvalid arrives during reset.
   -> all outputs at reset values; instr=32'h00000013; no instr_valid from the orphan response.
